// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma front end: default sizes, FSM state
// encoding and a constant-evaluable ceil(log2) helper.
package dsm_pkg;

  localparam int unsigned DSM_DATA_WIDTH = 16;
  localparam int unsigned DSM_OSR        = 64;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RAMP = 1'b1
  } dsm_state_t;

  // Smallest r with 2**r >= value.
  function automatic int unsigned dsm_clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsm_strobe_gen.sv
// Free-running divider: one-cycle strobe every EN_DIV clocks, starting on the
// first edge after reset release. tick_c is the decision, en its registered copy.
module dsm_strobe_gen
  import dsm_pkg::*;
#(
  parameter int unsigned EN_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_c,
  output logic en
);

  localparam int unsigned    CNT_W   = (EN_DIV > 1) ? dsm_clog2(EN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == '0);

  // Wrap-around divide counter and registered strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      en  <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
      en  <= tick_c;
    end
  end

endmodule

// File: rtl/dsm_interp.sv
// Oversampling interpolator feeding the delta-sigma modulator: produces OSR
// output samples per input sample, one per strobe.
// DSM_INTERP_LINEAR_EN defined: linear ramp from base to target.
// DSM_INTERP_LINEAR_EN undefined: zero-order hold of target.
module dsm_interp
  import dsm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DSM_DATA_WIDTH,
  parameter int unsigned OSR        = DSM_OSR,
  parameter int unsigned EN_DIV     = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_en,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_underrun
);

  localparam int unsigned  L      = dsm_clog2(OSR);
  localparam int unsigned  K_W    = L + 1;
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);
  localparam logic [K_W-1:0] K_OSR  = K_W'(OSR);
  localparam logic [K_W-1:0] K_LAST = K_W'(OSR - 1);

  dsm_state_t                   state, state_next;
  logic                         tick_c;
  logic [K_W-1:0]               k;
  logic                         pend_empty;
  logic signed [DATA_WIDTH-1:0] pend_data;
  logic signed [DATA_WIDTH-1:0] base;
  logic signed [DATA_WIDTH-1:0] target;
  logic                         accept_c;
  logic                         start_c;
  logic                         last_c;
  logic                         bypass_c;
  logic                         underrun_c;
  logic signed [DATA_WIDTH-1:0] src_c;
  logic signed [DATA_WIDTH-1:0] out_c;

`ifdef DSM_INTERP_LINEAR_EN
  localparam int unsigned D1_W  = DATA_WIDTH + 1;
  localparam int unsigned ACC_W = DATA_WIDTH + 1 + L;

  logic signed [D1_W-1:0]  delta;
  logic signed [D1_W-1:0]  delta_new_c;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next_c;
`endif

  dsm_strobe_gen #(
    .EN_DIV (EN_DIV)
  ) u_strobe (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .tick_c (tick_c),
    .en     (o_en)
  );

  assign o_ready = pend_empty;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_WAIT;
    else          state <= state_next;
  end

  // Next state: enter RAMP on segment start, fall back to WAIT on underrun
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT: if (start_c)    state_next = ST_RAMP;
      ST_RAMP: if (underrun_c) state_next = ST_WAIT;
      default:                 state_next = ST_WAIT;
    endcase
  end

  // Strobe decisions; an idle WAIT strobe can take the incoming sample directly
  always_comb begin
    accept_c = i_valid && pend_empty;
    src_c    = pend_empty ? i_data : pend_data;
    start_c  = 1'b0;
    last_c   = 1'b0;
    if (tick_c) begin
      if (state == ST_WAIT) begin
        start_c = !pend_empty || i_valid;
      end else begin
        start_c = (k == K_OSR);
        last_c  = (k == K_LAST);
      end
    end
    bypass_c   = accept_c && start_c;
    underrun_c = last_c && pend_empty;
  end

`ifdef DSM_INTERP_LINEAR_EN
  // Step value base + floor(delta*k / OSR) from the running delta*k sum
  always_comb begin
    delta_new_c = D1_W'(src_c) - D1_W'(base);
    acc_next_c  = start_c ? ACC_W'(delta_new_c) : acc + ACC_W'(delta);
    out_c       = DATA_WIDTH'(ACC_W'(base) + (acc_next_c >>> L));
  end
`else
  // Every step of a segment repeats the target
  always_comb begin
    out_c = start_c ? src_c : target;
  end
`endif

  // Segment registers and output sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k          <= '0;
      base       <= '0;
      target     <= '0;
      o_data     <= '0;
      o_underrun <= 1'b0;
`ifdef DSM_INTERP_LINEAR_EN
      delta      <= '0;
      acc        <= '0;
`endif
    end else begin
      o_underrun <= underrun_c;
      if (start_c) begin
        target <= src_c;
        k      <= K_ONE;
        o_data <= out_c;
`ifdef DSM_INTERP_LINEAR_EN
        delta  <= delta_new_c;
        acc    <= acc_next_c;
`endif
      end else if (tick_c && (state == ST_RAMP)) begin
        k      <= k + K_ONE;
        o_data <= out_c;
`ifdef DSM_INTERP_LINEAR_EN
        acc    <= acc_next_c;
`endif
        if (last_c) base <= target;
      end else if (tick_c) begin
        o_data <= base;
      end
    end
  end

  // One-entry pending register; bypassed samples never occupy it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_empty <= 1'b1;
      pend_data  <= '0;
    end else if (accept_c && !bypass_c) begin
      pend_empty <= 1'b0;
      pend_data  <= i_data;
    end else if (start_c && !pend_empty) begin
      pend_empty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dsm_interp.sv
// Directed bench for dsm_interp (DATA_WIDTH=16, OSR=4, EN_DIV=2). Expected
// sequences follow DSM_INTERP_LINEAR_EN the same way the design does.
module tb_dsm_interp;

  localparam int unsigned DW = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic signed [DW-1:0] i_data;
  logic                 o_en;
  logic signed [DW-1:0] o_data;
  logic                 o_underrun;

  int checks   = 0;
  int failures = 0;

  logic signed [DW-1:0] q_d[$];
  logic                 q_u[$];
  int                   urun_outside = 0;
  int                   hold_viol    = 0;
  logic signed [DW-1:0] prev_d;
  logic                 prev_rst = 1'b0;

  dsm_interp #(
    .DATA_WIDTH (16),
    .OSR        (4),
    .EN_DIV     (2)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .o_en       (o_en),
    .o_data     (o_data),
    .o_underrun (o_underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every strobed output; flag output changes or underruns off-strobe
  always @(negedge clk) begin
    if (rst_n && o_en) begin
      q_d.push_back(o_data);
      q_u.push_back(o_underrun);
    end
    if (rst_n && o_underrun && !o_en) urun_outside <= urun_outside + 1;
    if (rst_n && prev_rst && (o_data !== prev_d) && !o_en) hold_viol <= hold_viol + 1;
    prev_d   <= o_data;
    prev_rst <= rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic offer(input logic signed [DW-1:0] d);
    logic rdy;
    bit   done;
    done    = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      rdy = o_ready;
      step();
      if (rdy) done = 1'b1;
    end
    i_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL offer_timeout: got no accept expected accept of %0d", d);
    end
  endtask

  task automatic test_reset();
    int en_cnt, adj, nz;
    logic prev;
    rst_n   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_en !== 1'b0)       begin failures++; $display("FAIL rst_en: got %b expected 0", o_en); end
    checks++; if (o_data !== '0)       begin failures++; $display("FAIL rst_data: got %0d expected 0", o_data); end
    checks++; if (o_ready !== 1'b1)    begin failures++; $display("FAIL rst_ready: got %b expected 1", o_ready); end
    checks++; if (o_underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun: got %b expected 0", o_underrun); end
    step();
    step();
    q_d.delete(); q_u.delete();
    rst_n = 1'b1;
    en_cnt = 0; adj = 0; prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_en) en_cnt++;
      if (o_en && prev) adj++;
      prev = o_en;
    end
    nz = 0;
    foreach (q_d[i]) if (q_d[i] !== '0) nz++;
    checks++; if (en_cnt != 4) begin failures++; $display("FAIL cadence_count: got %0d expected 4", en_cnt); end
    checks++; if (adj != 0)    begin failures++; $display("FAIL cadence_adjacent: got %0d expected 0", adj); end
    checks++; if (nz != 0)     begin failures++; $display("FAIL idle_base: got %0d nonzero expected 0", nz); end
  endtask

  task automatic test_single();
`ifdef DSM_INTERP_LINEAR_EN
    int exp_d[6] = '{100, 200, 300, 400, 400, 400};
`else
    int exp_d[6] = '{400, 400, 400, 400, 400, 400};
`endif
    logic exp_u[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    step();
    q_d.delete(); q_u.delete();
    offer(16'sd400);
    repeat (14) step();
    checks++;
    if (q_d.size() < 6) begin failures++; $display("FAIL single_count: got %0d expected >=6", q_d.size()); end
    for (int i = 0; i < 6 && i < q_d.size(); i++) begin
      checks++;
      if (q_d[i] !== DW'(exp_d[i])) begin failures++; $display("FAIL single_data[%0d]: got %0d expected %0d", i, q_d[i], exp_d[i]); end
      checks++;
      if (q_u[i] !== exp_u[i]) begin failures++; $display("FAIL single_underrun[%0d]: got %b expected %b", i, q_u[i], exp_u[i]); end
    end
  endtask

  task automatic test_back_to_back();
`ifdef DSM_INTERP_LINEAR_EN
    int exp_d[8] = '{100, 200, 300, 400, 200, 0, -200, -400};
`else
    int exp_d[8] = '{400, 400, 400, 400, -400, -400, -400, -400};
`endif
    apply_reset();
    step();
    q_d.delete(); q_u.delete();
    offer(16'sd400);
    offer(-16'sd400);
    checks++;
    if (o_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_low: got %b expected 0", o_ready); end
    repeat (20) step();
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_high: got %b expected 1", o_ready); end
    checks++;
    if (q_d.size() < 8) begin failures++; $display("FAIL b2b_count: got %0d expected >=8", q_d.size()); end
    for (int i = 0; i < 8 && i < q_d.size(); i++) begin
      checks++;
      if (q_d[i] !== DW'(exp_d[i])) begin failures++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, q_d[i], exp_d[i]); end
      checks++;
      if (q_u[i] !== (i == 7)) begin failures++; $display("FAIL b2b_underrun[%0d]: got %b expected %b", i, q_u[i], (i == 7)); end
    end
  endtask

  task automatic test_extremes();
`ifdef DSM_INTERP_LINEAR_EN
    int exp_d[8] = '{8191, 16383, 24575, 32767, 16383, -1, -16385, -32768};
`else
    int exp_d[8] = '{32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768};
`endif
    apply_reset();
    step();
    q_d.delete(); q_u.delete();
    offer(16'sd32767);
    offer(-16'sd32768);
    repeat (20) step();
    checks++;
    if (q_d.size() < 8) begin failures++; $display("FAIL ext_count: got %0d expected >=8", q_d.size()); end
    for (int i = 0; i < 8 && i < q_d.size(); i++) begin
      checks++;
      if (q_d[i] !== DW'(exp_d[i])) begin failures++; $display("FAIL ext_data[%0d]: got %0d expected %0d", i, q_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_valid_held();
    int samp[5] = '{400, 800, 0, -400, 1200};
    int acc_cyc[5];
    int idx, cyc;
    logic rdy;
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_data  = DW'(samp[0]);
    step();
    step();
    q_d.delete(); q_u.delete();
    rst_n = 1'b1;
    idx = 0; cyc = 0;
    for (int n = 0; n < 100 && idx < 5; n++) begin
      rdy = o_ready;
      step();
      cyc++;
      if (rdy) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx == 1) begin
          checks++;
          if (o_ready !== 1'b1) begin failures++; $display("FAIL held_bypass_ready: got %b expected 1", o_ready); end
        end
        if (idx < 5) i_data = DW'(samp[idx]);
      end
    end
    i_valid = 1'b0;
    checks++;
    if (idx != 5) begin failures++; $display("FAIL held_accepts: got %0d expected 5", idx); end
    for (int i = 2; i < 5 && i < idx; i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 8) begin
        failures++;
        $display("FAIL held_spacing[%0d]: got %0d cycles expected 8", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    repeat (30) step();
    checks++;
    if (q_d.size() < 20) begin failures++; $display("FAIL held_count: got %0d expected >=20", q_d.size()); end
    for (int i = 0; i < 20 && i < q_d.size(); i++) begin
      int seg, kk, prv, expv;
      seg = i / 4;
      kk  = (i % 4) + 1;
      prv = (seg == 0) ? 0 : samp[seg-1];
`ifdef DSM_INTERP_LINEAR_EN
      expv = prv + ((samp[seg] - prv) * kk) / 4;
`else
      expv = samp[seg];
`endif
      checks++;
      if (q_d[i] !== DW'(expv)) begin failures++; $display("FAIL held_data[%0d]: got %0d expected %0d", i, q_d[i], expv); end
      checks++;
      if (q_u[i] !== (i == 19)) begin failures++; $display("FAIL held_underrun[%0d]: got %b expected %b", i, q_u[i], (i == 19)); end
    end
  endtask

  task automatic test_reset_mid();
    int en_cnt, adj, nz;
    logic prev;
`ifdef DSM_INTERP_LINEAR_EN
    int exp_d[4] = '{100, 200, 300, 400};
`else
    int exp_d[4] = '{400, 400, 400, 400};
`endif
    apply_reset();
    step();
    offer(16'sd400);
    offer(16'sd800);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (o_data !== '0)       begin failures++; $display("FAIL mid_rst_data: got %0d expected 0", o_data); end
    checks++; if (o_en !== 1'b0)       begin failures++; $display("FAIL mid_rst_en: got %b expected 0", o_en); end
    checks++; if (o_ready !== 1'b1)    begin failures++; $display("FAIL mid_rst_ready: got %b expected 1", o_ready); end
    checks++; if (o_underrun !== 1'b0) begin failures++; $display("FAIL mid_rst_underrun: got %b expected 0", o_underrun); end
    step();
    step();
    q_d.delete(); q_u.delete();
    rst_n = 1'b1;
    en_cnt = 0; adj = 0; prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_en) en_cnt++;
      if (o_en && prev) adj++;
      prev = o_en;
    end
    nz = 0;
    foreach (q_d[i]) if (q_d[i] !== '0) nz++;
    checks++; if (en_cnt != 4) begin failures++; $display("FAIL mid_cadence_count: got %0d expected 4", en_cnt); end
    checks++; if (adj != 0)    begin failures++; $display("FAIL mid_cadence_adjacent: got %0d expected 0", adj); end
    checks++; if (nz != 0)     begin failures++; $display("FAIL mid_pending_discard: got %0d nonzero expected 0", nz); end
    q_d.delete(); q_u.delete();
    offer(16'sd400);
    repeat (10) step();
    checks++;
    if (q_d.size() < 4) begin failures++; $display("FAIL mid_ramp_count: got %0d expected >=4", q_d.size()); end
    for (int i = 0; i < 4 && i < q_d.size(); i++) begin
      checks++;
      if (q_d[i] !== DW'(exp_d[i])) begin failures++; $display("FAIL mid_ramp_data[%0d]: got %0d expected %0d", i, q_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (hold_viol != 0)    begin failures++; $display("FAIL hold_between_strobes: got %0d changes expected 0", hold_viol); end
    checks++;
    if (urun_outside != 0) begin failures++; $display("FAIL underrun_off_strobe: got %0d expected 0", urun_outside); end
  endtask

  initial begin
    rst_n   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_extremes();
    test_valid_held();
    test_reset_mid();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsm_interp.md
DSM_INTERP -- requirements
Module: dsm_interp

Interface
REQ-001 Parameter DATA_WIDTH, default 16: sample width, signed two's complement.
REQ-002 Parameter OSR, default 64: output strobes per input sample; power of 2, >= 2; L = log2(OSR).
REQ-003 Parameter EN_DIV, default 1: clocks per output strobe, >= 1.
REQ-004 i_clk  input  1  single clock; all logic on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_valid  input  1  upstream sample valid.
REQ-007 o_ready  output  1  pending register empty; sample accepted when i_valid && o_ready.
REQ-008 i_data  input  DATA_WIDTH  signed input sample.
REQ-009 o_en  output  1  one-cycle strobe per output sample; drives the modulator i_en.
REQ-010 o_data  output  DATA_WIDTH  signed oversampled output; drives the modulator i_data.
REQ-011 o_underrun  output  1  one-cycle pulse when a segment ends with no pending sample.

Function
REQ-012 Strobe counter SHALL pulse o_en once every EN_DIV clocks, continuously from the first cycle after reset release, independent of data availability.
REQ-013 One-entry pending register SHALL capture i_data on accept; o_ready = pending empty.
REQ-014 FSM states: WAIT (hold base, no active segment) and RAMP (segment active, step counter k = 1..OSR).
REQ-015 WAIT, strobe, pending full: target = pending, delta = target - base (DATA_WIDTH+1 bits), pending cleared, k = 1, go RAMP; this strobe SHALL output step k=1.
REQ-016 WAIT, strobe, pending empty: o_data SHALL repeat base; stay WAIT.
REQ-017 RAMP step k: o_data = base + ((delta*k) >>> L), arithmetic shift (floor); incremental accumulator width DATA_WIDTH+1+L; no overflow or saturation needed since step OSR equals target exactly.
REQ-018 At step k=OSR: base = target; next strobe SHALL start a new segment directly if pending full (no gap, no repeated sample), else o_underrun pulses in the cycle of step OSR and state goes WAIT.
REQ-019 Accept and segment-start in same cycle with pending empty: incoming sample SHALL be used as target directly (bypass) and pending remains empty.
REQ-020 Accept and pending-consume in same cycle with pending full: impossible by o_ready; o_ready drops in the cycle after accept and rises in the cycle after consume.
REQ-021 o_data SHALL change only in cycles with o_en=1; registered output, one-cycle latency from strobe decision.

Reset
REQ-022 On i_rst_n=0: o_en=0, o_data=0, o_underrun=0, o_ready=1, base=0, pending empty, k=0, strobe counter=0, state WAIT.
REQ-023 Reset mid-segment SHALL discard pending and target; after release the output ramps from base 0.

Configuration
REQ-024 Macro DSM_INTERP_LINEAR_EN defined: linear interpolation per REQ-017.
REQ-025 Macro undefined: zero-order hold; every step k of a segment outputs target; accumulator and multiplier logic omitted; handshake, underrun and timing unchanged.

Structure
REQ-026 Package dsm_pkg SHALL hold DATA_WIDTH default, OSR default, FSM state typedef and clog2 helper, shared with the modulator.
REQ-027 Sub-module dsm_strobe_gen (EN_DIV divider producing o_en) SHALL be instantiated once.

Verification (DATA_WIDTH=16, OSR=4, EN_DIV=2, linear unless stated)
REQ-028 Reset asserted mid-run -> o_data=0, o_en=0, o_ready=1 asynchronously; o_en resumes every 2 clocks after release.
REQ-029 Single sample 400 from reset -> o_data on successive o_en: 100, 200, 300, 400; o_underrun pulse with step 400; then 400 held.
REQ-030 Back-to-back 400, -400 (second offered during first ramp) -> 100,200,300,400,200,0,-200,-400; no underrun; o_ready low while pending held.
REQ-031 Extremes 32767 then -32768 -> final values 32767 then -32768 exact; no wrap at any step (delta -65535 fits 17 bits).
REQ-032 i_valid held high continuously -> exactly one accept per 4 strobes, no sample lost or duplicated, bypass path exercised on first sample.
REQ-033 DSM_INTERP_LINEAR_EN undefined, sample 400 -> 400,400,400,400, o_underrun at fourth step.
